// File: rtl/mips_run_monitor.sv
// Run controller and result checker for the MIPS pipeline top: sequences the DUT
// reset, bounds the run length, decides pass/fail/timeout and logs recent stores.
module mips_run_monitor #(
  parameter int unsigned        ADDR_W     = 32,
  parameter int unsigned        DATA_W     = 32,
  parameter int unsigned        RST_CYCLES = 2,
  parameter int unsigned        MAX_CYCLES = 20,
  parameter int unsigned        CNT_W      = 16,
  parameter int unsigned        LOG_DEPTH  = 8,
  parameter logic [ADDR_W-1:0]  PASS_ADDR  = 84,
  parameter logic [DATA_W-1:0]  PASS_DATA  = 7,
  localparam int unsigned       PW         = $clog2(LOG_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  output logic              dut_reset,
  input  logic              memwrite,
  input  logic [ADDR_W-1:0] dataaddr,
  input  logic [DATA_W-1:0] writedata,
  input  logic [ADDR_W-1:0] pc,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic              timeout,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  store_count,
  output logic [PW:0]       log_count,
  input  logic [PW-1:0]     log_rd_idx,
  output logic [ADDR_W-1:0] log_rd_addr,
  output logic [DATA_W-1:0] log_rd_data
);

  typedef enum logic [2:0] {
    S_HOLD,
    S_RUN,
    S_PASS,
    S_FAIL,
    S_TIMEOUT
  } state_e;

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          hold_q;
  logic                      dut_reset_q;
  logic                      done_q, pass_q, fail_q, timeout_q;
  logic [CNT_W-1:0]          cycle_q, store_q;
  logic [PW:0]               logcnt_q;
  logic [PW-1:0]             wr_ptr_q;
  logic [ADDR_W+DATA_W-1:0]  log_q [LOG_DEPTH];

  logic                      sig_store;
  logic                      pc_misaligned;
  logic                      log_we;
  logic                      pc_unused_bits;
  logic [PW-1:0]             rd_ptr;

  assign sig_store      = memwrite && (dataaddr == PASS_ADDR);
  assign pc_misaligned  = |pc[1:0];
  assign pc_unused_bits = ^pc[ADDR_W-1:2];
  assign log_we         = !reset && (state_q == S_RUN) && memwrite;

  // Store verdict outranks a misaligned PC, which outranks the cycle bound.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HOLD: if (hold_q == CNT_W'(RST_CYCLES - 1)) state_d = S_RUN;
      S_RUN: begin
        if (sig_store)
          state_d = (writedata == PASS_DATA) ? S_PASS : S_FAIL;
        else if (pc_misaligned)
          state_d = S_FAIL;
        else if (cycle_q == CNT_W'(MAX_CYCLES - 1))
          state_d = S_TIMEOUT;
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_HOLD;
      hold_q      <= '0;
      dut_reset_q <= 1'b1;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      timeout_q   <= 1'b0;
      cycle_q     <= '0;
      store_q     <= '0;
      logcnt_q    <= '0;
      wr_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      dut_reset_q <= (state_d == S_HOLD);
      done_q      <= (state_d == S_PASS) || (state_d == S_FAIL) || (state_d == S_TIMEOUT);
      pass_q      <= (state_d == S_PASS);
      fail_q      <= (state_d == S_FAIL);
      timeout_q   <= (state_d == S_TIMEOUT);
      if (state_q == S_HOLD) hold_q <= hold_q + 1'b1;
      if (state_q == S_RUN) begin
        cycle_q <= cycle_q + 1'b1;
        if (memwrite) begin
          wr_ptr_q <= wr_ptr_q + 1'b1;
          if (store_q != '1) store_q <= store_q + 1'b1;
          if (logcnt_q != (PW+1)'(LOG_DEPTH)) logcnt_q <= logcnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (log_we) log_q[wr_ptr_q] <= {dataaddr, writedata};
  end

  // Index 0 is the entry just behind the write pointer; wrap is implicit in PW bits.
  assign rd_ptr = wr_ptr_q - PW'(1) - log_rd_idx;

  always_comb begin
    log_rd_addr = '0;
    log_rd_data = '0;
    if ({1'b0, log_rd_idx} < logcnt_q) begin
      {log_rd_addr, log_rd_data} = log_q[rd_ptr];
    end
  end

  assign dut_reset   = dut_reset_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign fail        = fail_q;
  assign timeout     = timeout_q;
  assign cycle_count = cycle_q;
  assign store_count = store_q;
  assign log_count   = logcnt_q;

endmodule

// File: tb/tb_mips_run_monitor.sv
// Directed self-checking bench for mips_run_monitor with hand-computed expectations.
module tb_mips_run_monitor;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        dut_reset;
  logic        memwrite = 1'b0;
  logic [31:0] dataaddr = '0;
  logic [31:0] writedata = '0;
  logic [31:0] pc = '0;
  logic        done, pass, fail, timeout;
  logic [15:0] cycle_count, store_count;
  logic [3:0]  log_count;
  logic [2:0]  log_rd_idx = '0;
  logic [31:0] log_rd_addr, log_rd_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mips_run_monitor #(
    .ADDR_W(32), .DATA_W(32), .RST_CYCLES(2), .MAX_CYCLES(20),
    .CNT_W(16), .LOG_DEPTH(8), .PASS_ADDR(32'd84), .PASS_DATA(32'd7)
  ) dut (
    .clk(clk), .reset(reset), .dut_reset(dut_reset),
    .memwrite(memwrite), .dataaddr(dataaddr), .writedata(writedata), .pc(pc),
    .done(done), .pass(pass), .fail(fail), .timeout(timeout),
    .cycle_count(cycle_count), .store_count(store_count), .log_count(log_count),
    .log_rd_idx(log_rd_idx), .log_rd_addr(log_rd_addr), .log_rd_data(log_rd_data)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_flags(input string tag, input logic [3:0] exp);
    check(tag, {60'd0, done, pass, fail, timeout}, {60'd0, exp});
  endtask

  // Reset for three cycles, release, and walk through HOLD into RUN cycle 1.
  task automatic start_run(input string tag);
    reset = 1'b1; memwrite = 1'b0; pc = '0;
    repeat (3) tick();
    check({tag, "_rst_dutrst"}, 64'(dut_reset), 64'd1);
    check_flags({tag, "_rst_flags"}, 4'b0000);
    check({tag, "_rst_counts"}, {cycle_count, store_count, 12'd0, log_count}, 64'd0);
    reset = 1'b0;
    tick();
    check({tag, "_hold1"}, 64'(dut_reset), 64'd1);
    tick();
    check({tag, "_run_entry"}, {31'd0, dut_reset, 16'd0, cycle_count}, 64'd0);
  endtask

  task automatic run_to(input logic [15:0] n);
    for (int i = 0; i < 100 && cycle_count != n; i++) tick();
    check("run_to", 64'(cycle_count), 64'(n));
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    memwrite = 1'b1; dataaddr = a; writedata = d;
    tick();
    memwrite = 1'b0; dataaddr = '0; writedata = '0;
  endtask

  task automatic read_log(input string tag, input logic [2:0] idx,
                          input logic [31:0] ea, input logic [31:0] ed);
    log_rd_idx = idx;
    #1;
    check(tag, {log_rd_addr, log_rd_data}, {ea, ed});
  endtask

  initial begin
    // Pass run: cycle counting, two stores, signature match, freeze.
    start_run("pass");
    tick();
    check("count1", 64'(cycle_count), 64'd1);
    tick();
    check("count2", 64'(cycle_count), 64'd2);
    run_to(3);
    store(32'd80, 32'h5);
    check_flags("after_plain_store", 4'b0000);
    run_to(9);
    store(32'd84, 32'h7);
    check_flags("pass_flags", 4'b1100);
    check("pass_cycles", 64'(cycle_count), 64'd10);
    check("pass_stores", {store_count, 12'd0, log_count}, {16'd2, 12'd0, 4'd2});
    read_log("pass_idx0", 3'd0, 32'd84, 32'd7);
    read_log("pass_idx1", 3'd1, 32'd80, 32'd5);
    read_log("pass_idx2", 3'd2, 32'd0, 32'd0);
    store(32'd8, 32'h9);
    repeat (3) tick();
    check("pass_frozen", {cycle_count, store_count, 12'd0, log_count}, {16'd10, 16'd2, 12'd0, 4'd2});
    check("pass_dutrst", 64'(dut_reset), 64'd0);
    check_flags("pass_sticky", 4'b1100);

    // Wrong signature data, later correct store ignored.
    start_run("bad");
    run_to(2);
    store(32'd84, 32'h8);
    check_flags("bad_flags", 4'b1010);
    check("bad_stores", 64'(store_count), 64'd1);
    store(32'd84, 32'h7);
    check_flags("bad_sticky", 4'b1010);
    check("bad_stores_frozen", 64'(store_count), 64'd1);

    // Timeout with no stores.
    start_run("to");
    run_to(19);
    check_flags("to_before", 4'b0000);
    tick();
    check_flags("to_flags", 4'b1001);
    check("to_cycles", 64'(cycle_count), 64'd20);

    // Signature store on the last allowed cycle beats timeout.
    start_run("late");
    run_to(19);
    store(32'd84, 32'h7);
    check_flags("late_flags", 4'b1100);
    check("late_cycles", 64'(cycle_count), 64'd20);

    // Log wrap: ten stores into an eight-entry log.
    start_run("wrap");
    for (int i = 0; i < 10; i++) store(32'(4 * i), 32'(100 + i));
    check("wrap_counts", {store_count, 12'd0, log_count}, {16'd10, 12'd0, 4'd8});
    check_flags("wrap_flags", 4'b0000);
    read_log("wrap_idx0", 3'd0, 32'd36, 32'd109);
    read_log("wrap_idx7", 3'd7, 32'd8, 32'd102);
    read_log("wrap_idx3", 3'd3, 32'd24, 32'd106);

    // Misaligned PC.
    start_run("pc");
    run_to(5);
    pc = 32'h6;
    tick();
    pc = '0;
    check_flags("pc_flags", 4'b1010);
    check("pc_cycles", 64'(cycle_count), 64'd6);

    // Misaligned PC with a passing signature store: the store decides.
    start_run("pcsig");
    run_to(4);
    pc = 32'h2;
    store(32'd84, 32'h7);
    pc = '0;
    check_flags("pcsig_flags", 4'b1100);

    // Reset mid-run restarts the sequence.
    start_run("mid");
    store(32'd16, 32'h1);
    run_to(4);
    reset = 1'b1;
    tick();
    check("mid_rst", {31'd0, dut_reset, 28'd0, done, pass, fail, timeout}, {31'd0, 1'b1, 32'd0});
    check("mid_counts", {cycle_count, store_count, 12'd0, log_count}, 64'd0);
    read_log("mid_log_empty", 3'd0, 32'd0, 32'd0);
    reset = 1'b0;
    tick();
    check("mid_hold1", 64'(dut_reset), 64'd1);
    tick();
    check("mid_run", {31'd0, dut_reset, 16'd0, cycle_count}, 64'd0);
    run_to(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
